// File: rtl/frame_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_ctrl_pkg
// Description : Shared types and helpers for the frame buffer sequencer.
//               Contains the sequencer state encoding and the row-index wrap
//               helper. The helper does not assume that the row count is a
//               power of two.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    // Callers pass an index below 2*rows, so a single conditional subtract
    // is enough to bring it back into 0..rows-1.
    function automatic int wrap_row(input int idx, input int rows);
        return (idx >= rows) ? (idx - rows) : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_position_counter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_position_counter
// Description : Column/row write-position counters for the frame buffer.
//               Wraps the column at P_COLUMNS-1, which advances the circular
//               row pointer and counts completed rows (saturating at
//               P_ROWS-1).
// Ports       : clk_i          clock, rising edge
//               rst_ni         asynchronous active-low reset
//               advance_i      step to the next pixel position
//               clear_i        restart at (0,0) with no filled rows; applied
//                              before advance_i in the same cycle
//               col_o          current column
//               row_o          current row
//               rows_filled_o  number of completed rows (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_position_counter
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int P_COLUMNS = 640,
    parameter int P_ROWS    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         advance_i,
    input  logic                         clear_i,
    output logic [$clog2(P_COLUMNS)-1:0] col_o,
    output logic [$clog2(P_ROWS)-1:0]    row_o,
    output logic [$clog2(P_ROWS)-1:0]    rows_filled_o
);

    localparam int CW = $clog2(P_COLUMNS);
    localparam int RW = $clog2(P_ROWS);
    localparam logic [CW-1:0] COL_LAST   = CW'(P_COLUMNS - 1);
    localparam logic [RW-1:0] FILLED_MAX = RW'(P_ROWS - 1);

    logic [CW-1:0] col_q, col_d, col_base;
    logic [RW-1:0] row_q, row_d, row_base;
    logic [RW-1:0] filled_q, filled_d, filled_base;

    always_comb begin
        col_base    = clear_i ? '0 : col_q;
        row_base    = clear_i ? '0 : row_q;
        filled_base = clear_i ? '0 : filled_q;
        col_d       = col_base;
        row_d       = row_base;
        filled_d    = filled_base;
        if (advance_i) begin
            if (col_base == COL_LAST) begin
                col_d    = '0;
                row_d    = RW'(wrap_row(int'(row_base) + 1, P_ROWS));
                filled_d = (filled_base == FILLED_MAX) ? filled_base
                                                       : filled_base + RW'(1);
            end else begin
                col_d = col_base + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q    <= '0;
            row_q    <= '0;
            filled_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            filled_q <= filled_d;
        end
    end

    assign col_o         = col_q;
    assign row_o         = row_q;
    assign rows_filled_o = filled_q;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_ctrl
// Description : Sequencer between the pixel stream and a single-port frame
//               buffer of P_ROWS circular rows. Each accepted pixel is
//               written at the current (column,row); once enough rows are
//               filled the same column is read back from the other rows and
//               a vertical window (oldest row in the MSB slice, newest pixel
//               in the LSB slice) is presented downstream.
// Ports       : I_CLK/I_RESET          clock, async active-low reset
//               I_ENABLE               low freezes the sequencer, no FB traffic
//               I_PIXEL/_VALID/I_SOF   pixel stream in, O_PIXEL_READY back
//               O_FB_*                 frame buffer control/address/write data
//               I_FB_PIXEL             frame buffer read data (1-cycle latency)
//               O_WINDOW/_COL/_VALID   window out, I_WINDOW_READY back
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 3,
    parameter int P_PIXEL_DEPTH = 24
) (
    input  logic                              I_CLK,
    input  logic                              I_RESET,
    input  logic                              I_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]          I_PIXEL,
    input  logic                              I_PIXEL_VALID,
    input  logic                              I_SOF,
    output logic                              O_PIXEL_READY,
    output logic                              O_FB_ENABLE,
    output logic [$clog2(P_COLUMNS)-1:0]      O_FB_COL,
    output logic [$clog2(P_ROWS)-1:0]         O_FB_ROW,
    output logic [P_PIXEL_DEPTH-1:0]          O_FB_PIXEL,
    output logic                              O_FB_WRITE_ENABLE,
    output logic                              O_FB_READ_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]          I_FB_PIXEL,
    output logic [P_ROWS*P_PIXEL_DEPTH-1:0]   O_WINDOW,
    output logic [$clog2(P_COLUMNS)-1:0]      O_WINDOW_COL,
    output logic                              O_WINDOW_VALID,
    input  logic                              I_WINDOW_READY
);

    localparam int CW = $clog2(P_COLUMNS);
    localparam int RW = $clog2(P_ROWS);
    localparam int D  = P_PIXEL_DEPTH;
    localparam logic [RW-1:0] K_LAST = RW'(P_ROWS - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] k_q, k_d;         // next read index to issue (1..P_ROWS-1)
    logic [RW-1:0] rd_k_q;           // index of the read issued last cycle
    logic          rd_vld_q;         // I_FB_PIXEL carries data this cycle
    logic [CW-1:0] wr_col_q;
    logic [RW-1:0] wr_row_q;
    logic [D-1:0]  win_q [P_ROWS];   // [0] = oldest row, [P_ROWS-1] = newest

    logic [CW-1:0] cnt_col, tgt_col;
    logic [RW-1:0] cnt_row, cnt_filled, tgt_row, tgt_filled, rd_row;
    logic          run, accept, wr_en, rd_en;

    assign run    = I_ENABLE && I_RESET;
    assign accept = run && (state_q == S_ACCEPT) && I_PIXEL_VALID;

    // A start-of-frame pixel goes to (0,0) and restarts the row priming.
    assign tgt_col    = I_SOF ? '0 : cnt_col;
    assign tgt_row    = I_SOF ? '0 : cnt_row;
    assign tgt_filled = I_SOF ? '0 : cnt_filled;

    // Oldest row sits just after the written row in the circular buffer.
    assign rd_row = RW'(wrap_row(int'(wr_row_q) + int'(k_q), P_ROWS));

    pixel_position_counter #(
        .P_COLUMNS (P_COLUMNS),
        .P_ROWS    (P_ROWS)
    ) u_pos (
        .clk_i         (I_CLK),
        .rst_ni        (I_RESET),
        .advance_i     (accept),
        .clear_i       (accept && I_SOF),
        .col_o         (cnt_col),
        .row_o         (cnt_row),
        .rows_filled_o (cnt_filled)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        O_FB_COL = wr_col_q;
        O_FB_ROW = rd_row;
        case (state_q)
            S_ACCEPT: begin
                O_FB_COL = tgt_col;
                O_FB_ROW = tgt_row;
                if (accept) begin
                    wr_en = 1'b1;
                    if (tgt_filled >= K_LAST) begin
                        state_d = S_READ;
                        k_d     = RW'(1);
                    end
                end
            end
            S_READ: begin
                if (run) begin
                    rd_en = 1'b1;
                    k_d   = k_q + RW'(1);
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end
                end else if (rd_vld_q) begin
                    // Read data returning while frozen is not captured, so
                    // that read is issued again once enable comes back.
                    k_d = rd_k_q;
                end
            end
            S_DRAIN: begin
                if (run) begin
                    state_d = S_OUTPUT;
                end else if (rd_vld_q) begin
                    state_d = S_READ;
                    k_d     = rd_k_q;
                end
            end
            S_OUTPUT: begin
                if (run && I_WINDOW_READY) begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            state_q  <= S_ACCEPT;
            k_q      <= '0;
            rd_k_q   <= '0;
            rd_vld_q <= 1'b0;
            wr_col_q <= '0;
            wr_row_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_k_q <= k_q;
            end
            if (accept) begin
                wr_col_q <= tgt_col;
                wr_row_q <= tgt_row;
            end
        end
    end

    // Slots 0..P_ROWS-2 take the read-back rows; the last slot takes the
    // written pixel itself.
    generate
        for (genvar i = 0; i < P_ROWS; i++) begin : g_slot
            if (i == P_ROWS - 1) begin : g_newest
                always_ff @(posedge I_CLK or negedge I_RESET) begin
                    if (!I_RESET) begin
                        win_q[i] <= '0;
                    end else if (accept) begin
                        win_q[i] <= I_PIXEL;
                    end
                end
            end else begin : g_read
                always_ff @(posedge I_CLK or negedge I_RESET) begin
                    if (!I_RESET) begin
                        win_q[i] <= '0;
                    end else if (I_ENABLE && rd_vld_q && (rd_k_q == RW'(i + 1))) begin
                        win_q[i] <= I_FB_PIXEL;
                    end
                end
            end
            assign O_WINDOW[(P_ROWS-1-i)*D +: D] = win_q[i];
        end
    endgenerate

    assign O_PIXEL_READY     = run && (state_q == S_ACCEPT);
    assign O_FB_ENABLE       = run;
    assign O_FB_PIXEL        = I_PIXEL;
    assign O_FB_WRITE_ENABLE = wr_en;
    assign O_FB_READ_ENABLE  = rd_en;
    assign O_WINDOW_COL      = wr_col_q;
    // Valid is withheld while frozen: the FSM cannot retire a handshake then.
    assign O_WINDOW_VALID    = run && (state_q == S_OUTPUT);

endmodule
`default_nettype wire
